// File: rtl/data_inf_rr_burst_arbiter_if.sv
// Valid/ready data stream bundle shared by the arbiter and its neighbours.
// Master drives valid/data, slaver drives ready.
interface data_inf #(
    parameter int DSIZE = 8
) ();
    logic             valid;
    logic             ready;
    logic [DSIZE-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slaver (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/data_inf_rr_burst_arbiter.sv
// Round-robin burst arbiter: NUM data_inf requesters share one master port,
// each grant lasting up to BURST beats or until the source drops valid.
module data_inf_rr_burst_arbiter #(
    parameter int NUM   = 8,
    parameter int NSIZE = $clog2(NUM),
    parameter int BURST = 16,
    localparam int CW   = (BURST == 0) ? 1 : $clog2(BURST + 1)
) (
    input  logic             clock,
    input  logic             rst_n,
    data_inf.slaver          s00 [NUM-1:0],
    data_inf.master          m00,
    output logic [NSIZE-1:0] curr_path,
    output logic             grant_vld,
    output logic [CW-1:0]    beat_cnt
);

    localparam int DSIZE = $bits(m00.data);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [NSIZE-1:0] curr_path_q, curr_path_d;
    logic [NSIZE-1:0] last_q, last_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;

    logic [NUM-1:0]   s_valid;
    logic [DSIZE-1:0] s_data [NUM];
    logic [NUM-1:0]   s_ready;

    logic             grant;
    logic             beat;
    logic             burst_done;
    logic             pick_found;
    logic [NSIZE-1:0] pick_idx;

    // Interface arrays only allow constant indices, so flatten them here.
    for (genvar k = 0; k < NUM; k++) begin : g_port
        assign s_valid[k]    = s00[k].valid;
        assign s_data[k]     = s00[k].data;
        assign s00[k].ready  = s_ready[k];
    end

    function automatic logic [NSIZE-1:0] wrap_idx(input int unsigned v);
        return NSIZE'(v % NUM);
    endfunction

    // Scan from last+NUM down to last+1 so the nearest successor wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NUM; i > 0; i--) begin
            if (s_valid[wrap_idx(32'(last_q) + 32'(i))]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(32'(last_q) + 32'(i));
            end
        end
    end

    assign grant      = (state_q == GRANT);
    assign beat       = grant && s_valid[curr_path_q] && m00.ready;
    assign burst_done = beat && (BURST != 0)
                        && (beat_cnt_q == CW'(BURST - 1));

    always_comb begin
        state_d     = state_q;
        curr_path_d = curr_path_q;
        last_d      = last_q;
        beat_cnt_d  = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    curr_path_d = pick_idx;
                    beat_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (beat && !(&beat_cnt_q)) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (!s_valid[curr_path_q] || burst_done) begin
                    state_d = IDLE;
                    last_d  = curr_path_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            curr_path_q <= '0;
            last_q      <= NSIZE'(NUM - 1);
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            curr_path_q <= curr_path_d;
            last_q      <= last_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    always_comb begin
        s_ready   = '0;
        m00.valid = 1'b0;
        m00.data  = '0;
        if (grant) begin
            m00.valid            = s_valid[curr_path_q];
            m00.data             = s_data[curr_path_q];
            s_ready[curr_path_q] = m00.ready;
        end
    end

    assign curr_path = curr_path_q;
    assign grant_vld = grant;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_data_inf_rr_burst_arbiter.sv
// Scenario bench for the round-robin burst arbiter, with a beat scoreboard
// and two instances (BURST=4 and unlimited) fed by the same sources.
`timescale 1ns/1ps
module tb_data_inf_rr_burst_arbiter;

    localparam int NUM = 4;
    localparam int DW  = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic m_ready;
    logic sel;

    always #5 clk = ~clk;

    int rem [NUM];
    int seq [NUM];
    int n_chk;
    int n_fail;

    logic [NUM-1:0] s_valid;
    logic [DW-1:0]  s_data [NUM];
    logic [NUM-1:0] rdy_a, rdy_b, rdy_sel;
    logic [DW-1:0]  exp_q [$];

    logic [1:0] cp_a, cp_b;
    logic       gv_a, gv_b;
    logic [2:0] bc_a;
    logic [0:0] bc_b;

    data_inf #(.DSIZE(DW)) sa [NUM-1:0] ();
    data_inf #(.DSIZE(DW)) sb [NUM-1:0] ();
    data_inf #(.DSIZE(DW)) ma ();
    data_inf #(.DSIZE(DW)) mb ();

    for (genvar g = 0; g < NUM; g++) begin : g_src
        assign sa[g].valid = s_valid[g];
        assign sa[g].data  = s_data[g];
        assign sb[g].valid = s_valid[g];
        assign sb[g].data  = s_data[g];
        assign rdy_a[g]    = sa[g].ready;
        assign rdy_b[g]    = sb[g].ready;
    end

    assign ma.ready = m_ready;
    assign mb.ready = m_ready;

    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            s_valid[i] = (rem[i] != 0);
            s_data[i]  = DW'((i << 6) | (seq[i] & 63));
        end
    end

    data_inf_rr_burst_arbiter #(.NUM(NUM), .BURST(4)) dut_a (
        .clock     (clk),
        .rst_n     (rst_n),
        .s00       (sa),
        .m00       (ma),
        .curr_path (cp_a),
        .grant_vld (gv_a),
        .beat_cnt  (bc_a)
    );

    data_inf_rr_burst_arbiter #(.NUM(NUM), .BURST(0)) dut_b (
        .clock     (clk),
        .rst_n     (rst_n),
        .s00       (sb),
        .m00       (mb),
        .curr_path (cp_b),
        .grant_vld (gv_b),
        .beat_cnt  (bc_b)
    );

    logic          mv;
    logic [DW-1:0] md;
    assign mv      = sel ? mb.valid : ma.valid;
    assign md      = sel ? mb.data  : ma.data;
    assign rdy_sel = sel ? rdy_b    : rdy_a;

    function automatic logic [DW-1:0] mk(input int src, input int k);
        return DW'((src << 6) | (k & 63));
    endfunction

    // Source model and beat monitor: beats are seen mid-cycle, sources
    // advance just after the edge that transferred the beat.
    always begin : monitor
        logic [NUM-1:0] fire;
        logic [DW-1:0]  e;
        @(negedge clk);
        fire = rdy_sel & s_valid;
        if (rst_n && mv && m_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got beat %h, expected none", md);
            end else begin
                e = exp_q.pop_front();
                if (md !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h expected %h", md, e);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM; i++) begin
            if (fire[i] && rst_n) begin
                seq[i]++;
                if (rem[i] > 0) rem[i]--;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        exp_q.delete();
        #10;
        rst_n = 1'b1;
        step();
    endtask

    task automatic check_drained(input string nm);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending, expected 0",
                     nm, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        for (int i = 0; i < NUM; i++) rem[i] = -1;
        #2;
        n_chk++;
        if ({ma.valid, rdy_a, gv_a, cp_a, bc_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got v%b r%b g%b p%0d c%0d, expected 0",
                     ma.valid, rdy_a, gv_a, cp_a, bc_a);
        end
        n_chk++;
        if ({mb.valid, rdy_b, gv_b, cp_b, bc_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got v%b r%b g%b p%0d c%0d, expected 0",
                     mb.valid, rdy_b, gv_b, cp_b, bc_b);
        end
        step();
        step();
        for (int i = 0; i < NUM; i++) rem[i] = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_source();
        logic exp_g;
        do_reset();
        rem[2] = 3;
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(2, k));
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) step();
            @(negedge clk);
            exp_g = (c >= 1 && c <= 4);
            n_chk++;
            if (gv_a !== exp_g) begin
                n_fail++;
                $display("FAIL single_grant c%0d: got %b expected %b",
                         c, gv_a, exp_g);
            end
            if (c == 4) begin
                n_chk++;
                if (ma.valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_drop: got valid %b expected 0",
                             ma.valid);
                end
            end
            if (c == 5) begin
                n_chk++;
                if (cp_a !== 2'd2) begin
                    n_fail++;
                    $display("FAIL single_path: got %0d expected 2", cp_a);
                end
            end
        end
        check_drained("single");
    endtask

    task automatic test_fairness();
        int ord [5];
        int eseq [NUM];
        int beats;
        logic exp_g;
        do_reset();
        for (int i = 0; i < NUM; i++) begin
            rem[i]  = -1;
            eseq[i] = 0;
        end
        for (int k = 0; k < 5; k++) begin
            ord[k] = (NUM - 1 + 1 + k) % NUM;
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(mk(ord[k], eseq[ord[k]]));
                eseq[ord[k]]++;
            end
        end
        beats = 0;
        for (int c = 1; c <= 25; c++) begin
            step();
            @(negedge clk);
            exp_g = ((c - 1) % 5) != 4;
            n_chk++;
            if (gv_a !== exp_g) begin
                n_fail++;
                $display("FAIL fair_grant c%0d: got %b expected %b",
                         c, gv_a, exp_g);
            end
            if (exp_g) begin
                n_chk++;
                if (cp_a !== 2'(ord[(c - 1) / 5]) ||
                    bc_a !== 3'((c - 1) % 5)) begin
                    n_fail++;
                    $display("FAIL fair_path c%0d: got p%0d c%0d expected p%0d c%0d",
                             c, cp_a, bc_a, ord[(c - 1) / 5], (c - 1) % 5);
                end
            end
            if (ma.valid && m_ready) beats++;
        end
        n_chk++;
        if (beats != 20) begin
            n_fail++;
            $display("FAIL fair_eff: got %0d beats in 25 cycles expected 20",
                     beats);
        end
        step();
        for (int i = 0; i < NUM; i++) rem[i] = 0;
        step();
        step();
        check_drained("fair");
    endtask

    task automatic test_backpressure();
        int exp_c [9];
        exp_c = '{0, 0, 1, 2, 2, 2, 2, 3, 0};
        do_reset();
        rem[1] = -1;
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(1, k));
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 3) m_ready = 1'b0;
            if (c == 6) m_ready = 1'b1;
            if (c == 8) rem[1] = 0;
            @(negedge clk);
            n_chk++;
            if (gv_a !== (c <= 7)) begin
                n_fail++;
                $display("FAIL bp_grant c%0d: got %b expected %b",
                         c, gv_a, c <= 7);
            end
            if (c <= 7) begin
                n_chk++;
                if (bc_a !== 3'(exp_c[c])) begin
                    n_fail++;
                    $display("FAIL bp_count c%0d: got %0d expected %0d",
                             c, bc_a, exp_c[c]);
                end
            end
            if (c >= 3 && c <= 5) begin
                n_chk++;
                if (ma.data !== mk(1, 2) || ma.valid !== 1'b1 ||
                    rdy_a !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL bp_hold c%0d: got d%h v%b r%b expected d%h v1 r0000",
                             c, ma.data, ma.valid, rdy_a, mk(1, 2));
                end
            end
        end
        check_drained("bp");
    endtask

    task automatic test_mid_reset();
        do_reset();
        rem[3] = -1;
        exp_q.push_back(mk(3, 0));
        step();
        @(negedge clk);
        n_chk++;
        if (gv_a !== 1'b1 || cp_a !== 2'd3) begin
            n_fail++;
            $display("FAIL mrst_grant: got g%b p%0d expected g1 p3", gv_a, cp_a);
        end
        step();
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < NUM; i++) rem[i] = 0;
        rem[1] = 1;
        rem[2] = 1;
        #1;
        n_chk++;
        if ({ma.valid, rdy_a, gv_a, cp_a, bc_a} !== '0) begin
            n_fail++;
            $display("FAIL mrst_async: got v%b r%b g%b p%0d c%0d, expected 0",
                     ma.valid, rdy_a, gv_a, cp_a, bc_a);
        end
        exp_q.push_back(mk(1, 0));
        exp_q.push_back(mk(2, 0));
        #8;
        rst_n = 1'b1;
        for (int c = 3; c <= 8; c++) begin
            if (c > 3) step();
            @(negedge clk);
            if (c == 3 || c == 6) begin
                n_chk++;
                if (gv_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mrst_idle c%0d: got %b expected 0", c, gv_a);
                end
            end
            if (c == 4 || c == 7) begin
                n_chk++;
                if (gv_a !== 1'b1 || cp_a !== ((c == 4) ? 2'd1 : 2'd2)) begin
                    n_fail++;
                    $display("FAIL mrst_pick c%0d: got g%b p%0d expected g1 p%0d",
                             c, gv_a, cp_a, (c == 4) ? 1 : 2);
                end
            end
        end
        check_drained("mrst");
    endtask

    task automatic test_unlimited();
        sel = 1'b1;
        do_reset();
        rem[1] = 20;
        rem[3] = -1;
        for (int k = 0; k < 20; k++) exp_q.push_back(mk(1, k));
        exp_q.push_back(mk(3, 0));
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 24) rem[3] = 0;
            @(negedge clk);
            if (c <= 20) begin
                n_chk++;
                if (gv_b !== 1'b1 || cp_b !== 2'd1 || rdy_b[3] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL unl_hold c%0d: got g%b p%0d r3=%b expected g1 p1 r3=0",
                             c, gv_b, cp_b, rdy_b[3]);
                end
            end
            if (c == 20) begin
                n_chk++;
                if (bc_b !== 1'b1) begin
                    n_fail++;
                    $display("FAIL unl_sat: got %0d expected 1", bc_b);
                end
            end
            if (c == 21) begin
                n_chk++;
                if (gv_b !== 1'b1 || mb.valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL unl_drop: got g%b v%b expected g1 v0",
                             gv_b, mb.valid);
                end
            end
            if (c == 22) begin
                n_chk++;
                if (gv_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL unl_idle: got %b expected 0", gv_b);
                end
            end
            if (c == 23) begin
                n_chk++;
                if (gv_b !== 1'b1 || cp_b !== 2'd3) begin
                    n_fail++;
                    $display("FAIL unl_next: got g%b p%0d expected g1 p3",
                             gv_b, cp_b);
                end
            end
        end
        step();
        step();
        check_drained("unl");
        sel = 1'b0;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        sel     = 1'b0;
        m_ready = 1'b1;
        rst_n   = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        test_reset();
        test_single_source();
        test_fairness();
        test_backpressure();
        test_mid_reset();
        test_unlimited();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
